// File: rtl/stk_pipe_mem_ctrl_pkg.sv
// Shared sizes and types for the stk pipeline SRAM sequencer/arbiter.
// Enum encodings are fixed so state and priority flags read cleanly in waveforms.
package stk_pipe_mem_ctrl_pkg;

    localparam int BANKS_N = 4;
    localparam int LINES_N = 256;
    localparam int DATA_W  = 128;
    localparam int LINE_W  = $clog2(LINES_N);
    localparam int BANK_W  = (BANKS_N > 1) ? $clog2(BANKS_N) : 1;

    typedef logic [LINE_W-1:0] line_id_t;
    typedef logic [BANK_W-1:0] bank_id_t;

    typedef enum logic {
        CTRL_INIT = 1'b0,
        CTRL_DONE = 1'b1
    } ctrl_state_t;

    typedef enum logic {
        PRIO_WB = 1'b0,
        PRIO_LK = 1'b1
    } prio_t;

    typedef struct packed {
        logic dat;
        logic tail;
        logic head;
    } wr_sel_t;

endpackage

// File: rtl/stk_pipe_mem_ctrl_if.sv
// Request, response and SRAM buses of the stk memory controller.
// master = controller side, slave = requesters plus the SRAM macros.
interface stk_pipe_mem_ctrl_if #(
    parameter int BANKS_N = stk_pipe_mem_ctrl_pkg::BANKS_N,
    parameter int LINES_N = stk_pipe_mem_ctrl_pkg::LINES_N,
    parameter int DATA_W  = stk_pipe_mem_ctrl_pkg::DATA_W
) ();
    import stk_pipe_mem_ctrl_pkg::*;

    localparam int LINE_W = $clog2(LINES_N);

    logic                              i_reinit;
    logic                              o_init_busy;

    logic [BANKS_N-1:0]                i_lk_rd_vld;
    logic [BANKS_N-1:0][LINE_W-1:0]    i_lk_rd_addr;
    logic [BANKS_N-1:0]                o_lk_rd_stall;
    logic [BANKS_N-1:0]                o_lk_rd_dvld;
    logic [BANKS_N-1:0][LINE_W-1:0]    o_lk_rd_head;
    logic [BANKS_N-1:0][LINE_W-1:0]    o_lk_rd_tail;
    logic [BANKS_N-1:0][DATA_W-1:0]    o_lk_rd_dat;

    logic [BANKS_N-1:0]                i_wb_wr_vld;
    wr_sel_t [BANKS_N-1:0]             i_wb_wr_sel;
    logic [BANKS_N-1:0][LINE_W-1:0]    i_wb_wr_addr;
    logic [BANKS_N-1:0][LINE_W-1:0]    i_wb_wr_head;
    logic [BANKS_N-1:0][LINE_W-1:0]    i_wb_wr_tail;
    logic [BANKS_N-1:0][DATA_W-1:0]    i_wb_wr_dat;
    logic [BANKS_N-1:0]                o_wb_wr_stall;

    logic [BANKS_N-1:0]                o_head_ce, o_head_oe;
    logic [BANKS_N-1:0]                o_tail_ce, o_tail_oe;
    logic [BANKS_N-1:0]                o_dat_ce,  o_dat_oe;
    logic [BANKS_N-1:0][LINE_W-1:0]    o_head_addr, o_tail_addr, o_dat_addr;
    logic [BANKS_N-1:0][LINE_W-1:0]    o_head_din, o_tail_din;
    logic [BANKS_N-1:0][DATA_W-1:0]    o_dat_din;
    logic [BANKS_N-1:0][LINE_W-1:0]    i_head_dout, i_tail_dout;
    logic [BANKS_N-1:0][DATA_W-1:0]    i_dat_dout;

    modport master (
        input  i_reinit, i_lk_rd_vld, i_lk_rd_addr,
        input  i_wb_wr_vld, i_wb_wr_sel, i_wb_wr_addr, i_wb_wr_head, i_wb_wr_tail, i_wb_wr_dat,
        input  i_head_dout, i_tail_dout, i_dat_dout,
        output o_init_busy, o_lk_rd_stall, o_lk_rd_dvld, o_lk_rd_head, o_lk_rd_tail, o_lk_rd_dat,
        output o_wb_wr_stall,
        output o_head_ce, o_head_oe, o_tail_ce, o_tail_oe, o_dat_ce, o_dat_oe,
        output o_head_addr, o_tail_addr, o_dat_addr, o_head_din, o_tail_din, o_dat_din
    );

    modport slave (
        output i_reinit, i_lk_rd_vld, i_lk_rd_addr,
        output i_wb_wr_vld, i_wb_wr_sel, i_wb_wr_addr, i_wb_wr_head, i_wb_wr_tail, i_wb_wr_dat,
        output i_head_dout, i_tail_dout, i_dat_dout,
        input  o_init_busy, o_lk_rd_stall, o_lk_rd_dvld, o_lk_rd_head, o_lk_rd_tail, o_lk_rd_dat,
        input  o_wb_wr_stall,
        input  o_head_ce, o_head_oe, o_tail_ce, o_tail_oe, o_dat_ce, o_dat_oe,
        input  o_head_addr, o_tail_addr, o_dat_addr, o_head_din, o_tail_din, o_dat_din
    );

endinterface

// File: rtl/stk_pipe_mem_ctrl_bank_arb.sv
// Per-bank read/write arbiter with a toggling priority flag (fair under conflict).
// Latency: grants and stalls are combinational from the requests; the flag updates on the edge.
// Backpressure: the losing side, or every side while en_i is low, sees stall=1 and must hold.
module stk_pipe_mem_ctrl_bank_arb
    import stk_pipe_mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic en_i,
    input  logic rd_vld_i,
    input  logic wr_vld_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o,
    output logic rd_stall_o,
    output logic wr_stall_o
);

    prio_t prio_q, prio_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prio_q <= PRIO_WB;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        rd_gnt_o   = 1'b0;
        wr_gnt_o   = 1'b0;
        rd_stall_o = 1'b1;
        wr_stall_o = 1'b1;
        prio_d     = prio_q;
        if (en_i) begin
            // On a conflict the winner hands priority to the side it just stalled.
            if (rd_vld_i && wr_vld_i) begin
                if (prio_q == PRIO_WB) begin
                    wr_gnt_o = 1'b1;
                    prio_d   = PRIO_LK;
                end else begin
                    rd_gnt_o = 1'b1;
                    prio_d   = PRIO_WB;
                end
            end else begin
                wr_gnt_o = wr_vld_i;
                rd_gnt_o = rd_vld_i;
            end
            rd_stall_o = rd_vld_i && !rd_gnt_o;
            wr_stall_o = wr_vld_i && !wr_gnt_o;
        end
    end

endmodule

// File: rtl/stk_pipe_mem_ctrl.sv
// Init sweep + per-bank LK/WB arbitration over the head/tail/data SRAMs; STK_MEM_CTRL_INIT_DAT_EN also clears data.
// Latency: SRAM controls are combinational from grants; o_lk_rd_dvld one cycle after a read grant.
// Backpressure: all requests stall during the sweep; afterwards only the arbitration loser stalls.
module stk_pipe_mem_ctrl
    import stk_pipe_mem_ctrl_pkg::*;
#(
    parameter int BANKS_N = stk_pipe_mem_ctrl_pkg::BANKS_N,
    parameter int LINES_N = stk_pipe_mem_ctrl_pkg::LINES_N,
    parameter int DATA_W  = stk_pipe_mem_ctrl_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 arst_n,
    stk_pipe_mem_ctrl_if.master  bus
);

    localparam int                LINE_W    = $clog2(LINES_N);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_N - 1);

    ctrl_state_t          state_q, state_d;
    logic [LINE_W-1:0]    cnt_q, cnt_d;
    logic [BANKS_N-1:0]   dvld_q;
    logic [BANKS_N-1:0]   rd_gnt, wr_gnt, rd_stall, wr_stall;
    logic                 done;

    assign done = (state_q == CTRL_DONE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= CTRL_INIT;
            cnt_q   <= '0;
            dvld_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvld_q  <= rd_gnt;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CTRL_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_LINE) begin
                    state_d = CTRL_DONE;
                    cnt_d   = '0;
                end
            end
            CTRL_DONE: begin
                if (bus.i_reinit) begin
                    state_d = CTRL_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = CTRL_INIT;
        endcase
    end

    for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
        stk_pipe_mem_ctrl_bank_arb u_arb (
            .clk        (clk),
            .arst_n     (arst_n),
            .en_i       (done),
            .rd_vld_i   (bus.i_lk_rd_vld[b]),
            .wr_vld_i   (bus.i_wb_wr_vld[b]),
            .rd_gnt_o   (rd_gnt[b]),
            .wr_gnt_o   (wr_gnt[b]),
            .rd_stall_o (rd_stall[b]),
            .wr_stall_o (wr_stall[b])
        );

        a_lk_hold: assert property (@(posedge clk) disable iff (!arst_n)
            (bus.i_lk_rd_vld[b] && bus.o_lk_rd_stall[b]) |=>
            (bus.i_lk_rd_vld[b] && $stable(bus.i_lk_rd_addr[b])));

        a_wb_hold: assert property (@(posedge clk) disable iff (!arst_n)
            (bus.i_wb_wr_vld[b] && bus.o_wb_wr_stall[b]) |=>
            (bus.i_wb_wr_vld[b] && $stable(bus.i_wb_wr_sel[b]) && $stable(bus.i_wb_wr_addr[b]) &&
             $stable(bus.i_wb_wr_head[b]) && $stable(bus.i_wb_wr_tail[b]) &&
             $stable(bus.i_wb_wr_dat[b])));
    end

    assign bus.o_init_busy   = !done;
    assign bus.o_lk_rd_stall = rd_stall;
    assign bus.o_wb_wr_stall = wr_stall;
    assign bus.o_lk_rd_dvld  = dvld_q;
    assign bus.o_lk_rd_head  = bus.i_head_dout;
    assign bus.o_lk_rd_tail  = bus.i_tail_dout;
    assign bus.o_lk_rd_dat   = bus.i_dat_dout;

    always_comb begin
        bus.o_head_ce   = '0;
        bus.o_head_oe   = '0;
        bus.o_tail_ce   = '0;
        bus.o_tail_oe   = '0;
        bus.o_dat_ce    = '0;
        bus.o_dat_oe    = '0;
        bus.o_head_addr = '0;
        bus.o_tail_addr = '0;
        bus.o_dat_addr  = '0;
        bus.o_head_din  = '0;
        bus.o_tail_din  = '0;
        bus.o_dat_din   = '0;
        for (int b = 0; b < BANKS_N; b++) begin
            if (!done) begin
                bus.o_head_ce[b]   = 1'b1;
                bus.o_tail_ce[b]   = 1'b1;
                bus.o_head_addr[b] = cnt_q;
                bus.o_tail_addr[b] = cnt_q;
`ifdef STK_MEM_CTRL_INIT_DAT_EN
                bus.o_dat_ce[b]    = 1'b1;
                bus.o_dat_addr[b]  = cnt_q;
`endif
            end else if (wr_gnt[b]) begin
                // A write with an empty select is accepted but touches no SRAM.
                bus.o_head_ce[b]   = bus.i_wb_wr_sel[b].head;
                bus.o_tail_ce[b]   = bus.i_wb_wr_sel[b].tail;
                bus.o_dat_ce[b]    = bus.i_wb_wr_sel[b].dat;
                bus.o_head_addr[b] = bus.i_wb_wr_addr[b];
                bus.o_tail_addr[b] = bus.i_wb_wr_addr[b];
                bus.o_dat_addr[b]  = bus.i_wb_wr_addr[b];
                bus.o_head_din[b]  = bus.i_wb_wr_head[b];
                bus.o_tail_din[b]  = bus.i_wb_wr_tail[b];
                bus.o_dat_din[b]   = bus.i_wb_wr_dat[b];
            end else if (rd_gnt[b]) begin
                bus.o_head_ce[b]   = 1'b1;
                bus.o_tail_ce[b]   = 1'b1;
                bus.o_dat_ce[b]    = 1'b1;
                bus.o_head_oe[b]   = 1'b1;
                bus.o_tail_oe[b]   = 1'b1;
                bus.o_dat_oe[b]    = 1'b1;
                bus.o_head_addr[b] = bus.i_lk_rd_addr[b];
                bus.o_tail_addr[b] = bus.i_lk_rd_addr[b];
                bus.o_dat_addr[b]  = bus.i_lk_rd_addr[b];
            end
        end
    end

endmodule

// File: tb/tb_stk_pipe_mem_ctrl.sv
// Directed bench for stk_pipe_mem_ctrl with a behavioural SRAM per bank.
module tb_stk_pipe_mem_ctrl;
    import stk_pipe_mem_ctrl_pkg::*;

    localparam int LW = $clog2(LINES_N);

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    stk_pipe_mem_ctrl_if #(.BANKS_N(BANKS_N), .LINES_N(LINES_N), .DATA_W(DATA_W)) bus ();

    stk_pipe_mem_ctrl #(.BANKS_N(BANKS_N), .LINES_N(LINES_N), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    logic [LW-1:0]     head_mem [BANKS_N][LINES_N];
    logic [LW-1:0]     tail_mem [BANKS_N][LINES_N];
    logic [DATA_W-1:0] dat_mem  [BANKS_N][LINES_N];

    always @(posedge clk) begin
        for (int b = 0; b < BANKS_N; b++) begin
            if (bus.o_head_ce[b]) begin
                if (bus.o_head_oe[b]) bus.i_head_dout[b] <= head_mem[b][bus.o_head_addr[b]];
                else                  head_mem[b][bus.o_head_addr[b]] <= bus.o_head_din[b];
            end
            if (bus.o_tail_ce[b]) begin
                if (bus.o_tail_oe[b]) bus.i_tail_dout[b] <= tail_mem[b][bus.o_tail_addr[b]];
                else                  tail_mem[b][bus.o_tail_addr[b]] <= bus.o_tail_din[b];
            end
            if (bus.o_dat_ce[b]) begin
                if (bus.o_dat_oe[b]) bus.i_dat_dout[b] <= dat_mem[b][bus.o_dat_addr[b]];
                else                 dat_mem[b][bus.o_dat_addr[b]] <= bus.o_dat_din[b];
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.i_reinit     = 1'b0;
        bus.i_lk_rd_vld  = '0;
        bus.i_lk_rd_addr = '0;
        bus.i_wb_wr_vld  = '0;
        bus.i_wb_wr_sel  = '0;
        bus.i_wb_wr_addr = '0;
        bus.i_wb_wr_head = '0;
        bus.i_wb_wr_tail = '0;
        bus.i_wb_wr_dat  = '0;
    endtask

    function automatic logic sweep_ok(input int k);
        logic ok;
        ok = bus.o_init_busy;
        for (int b = 0; b < BANKS_N; b++) begin
            ok &= bus.o_head_ce[b] & bus.o_tail_ce[b] & !bus.o_head_oe[b] & !bus.o_tail_oe[b];
            ok &= (bus.o_head_addr[b] == LW'(k)) && (bus.o_tail_addr[b] == LW'(k));
            ok &= (bus.o_head_din[b] == '0) && (bus.o_tail_din[b] == '0);
            ok &= bus.o_lk_rd_stall[b] & bus.o_wb_wr_stall[b];
`ifdef STK_MEM_CTRL_INIT_DAT_EN
            ok &= bus.o_dat_ce[b] & !bus.o_dat_oe[b] & (bus.o_dat_addr[b] == LW'(k));
`else
            ok &= !bus.o_dat_ce[b];
`endif
        end
        return ok;
    endfunction

    // Runs a full sweep from the current counter value 0, one check per cycle.
    task automatic run_sweep(input string name, input int reinit_at);
        for (int k = 0; k < LINES_N; k++) begin
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", name, k), {127'd0, sweep_ok(k)}, 128'd1);
            tick();
            bus.i_reinit = 1'b0;
            if (k + 1 == reinit_at) bus.i_reinit = 1'b1;
        end
        bus.i_reinit = 1'b0;
        @(negedge clk);
        chk({name, "_busy_end"}, {127'd0, bus.o_init_busy}, 128'd0);
    endtask

    typedef struct {
        logic [BANKS_N-1:0] rd, wr;
        wr_sel_t            sel;
        logic [BANKS_N-1:0] rd_st, wr_st, head_ce, head_oe, dat_ce, dvld;
    } vec_t;

    vec_t vt [6];

    initial begin
        // rd, wr, sel, rd_stall, wr_stall, head_ce, head_oe, dat_ce, dvld
        vt[0] = '{4'b1111, 4'b1111, wr_sel_t'(3'b111), 4'b1101, 4'b0010, 4'b1111, 4'b0010, 4'b1111, 4'b0000};
        vt[1] = '{4'b1111, 4'b1111, wr_sel_t'(3'b111), 4'b0010, 4'b1101, 4'b1111, 4'b1101, 4'b1111, 4'b0010};
        vt[2] = '{4'b0010, 4'b1101, wr_sel_t'(3'b111), 4'b0000, 4'b0000, 4'b1111, 4'b0010, 4'b1111, 4'b1101};
        vt[3] = '{4'b0000, 4'b0001, wr_sel_t'(3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        vt[4] = '{4'b0100, 4'b0000, wr_sel_t'(3'b000), 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        vt[5] = '{4'b0000, 4'b0000, wr_sel_t'(3'b000), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};

        clr_req();
        #12;
        chk("rst_busy",     {127'd0, bus.o_init_busy}, 128'd1);
        chk("rst_dvld",     {124'd0, bus.o_lk_rd_dvld}, 128'd0);
        chk("rst_rd_stall", {124'd0, bus.o_lk_rd_stall}, 128'hF);
        chk("rst_head_addr", {120'd0, bus.o_head_addr[0]}, 128'd0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        run_sweep("init", -1);
        chk("done_rd_stall", {124'd0, bus.o_lk_rd_stall}, 128'd0);
        chk("done_wr_stall", {124'd0, bus.o_wb_wr_stall}, 128'd0);

        // bank 2: write all three SRAMs at 0x17, then read it back
        tick();
        bus.i_wb_wr_vld[2]  = 1'b1;
        bus.i_wb_wr_sel[2]  = wr_sel_t'(3'b111);
        bus.i_wb_wr_addr[2] = 8'h17;
        bus.i_wb_wr_head[2] = 8'h33;
        bus.i_wb_wr_tail[2] = 8'h44;
        bus.i_wb_wr_dat[2]  = {4{32'h1234_5678}};
        @(negedge clk);
        chk("b2_wr_head_ce", {124'd0, bus.o_head_ce}, 128'b0100);
        chk("b2_wr_oe",      {124'd0, bus.o_head_oe | bus.o_tail_oe | bus.o_dat_oe}, 128'd0);
        tick();
        clr_req();
        bus.i_lk_rd_vld[2]  = 1'b1;
        bus.i_lk_rd_addr[2] = 8'h17;
        @(negedge clk);
        chk("b2_rd_ce", {124'd0, bus.o_head_ce & bus.o_tail_ce & bus.o_dat_ce}, 128'b0100);
        chk("b2_rd_oe", {124'd0, bus.o_head_oe & bus.o_tail_oe & bus.o_dat_oe}, 128'b0100);
        chk("b2_rd_addr", {120'd0, bus.o_head_addr[2] & bus.o_tail_addr[2] & bus.o_dat_addr[2]}, 128'h17);
        chk("b2_rd_dvld_early", {124'd0, bus.o_lk_rd_dvld}, 128'd0);
        tick();
        clr_req();
        @(negedge clk);
        chk("b2_dvld", {124'd0, bus.o_lk_rd_dvld}, 128'b0100);
        chk("b2_head", {120'd0, bus.o_lk_rd_head[2]}, 128'h33);
        chk("b2_tail", {120'd0, bus.o_lk_rd_tail[2]}, 128'h44);
        chk("b2_dat",  bus.o_lk_rd_dat[2], {4{32'h1234_5678}});

        // bank 1: held read+write conflict alternates WB, LK, WB, LK
        tick();
        bus.i_lk_rd_vld[1]  = 1'b1;
        bus.i_lk_rd_addr[1] = 8'h41;
        bus.i_wb_wr_vld[1]  = 1'b1;
        bus.i_wb_wr_sel[1]  = wr_sel_t'(3'b001);
        bus.i_wb_wr_addr[1] = 8'h40;
        bus.i_wb_wr_head[1] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("conf%0d_wr_stall", i), {127'd0, bus.o_wb_wr_stall[1]}, {127'd0, i[0]});
            chk($sformatf("conf%0d_rd_stall", i), {127'd0, bus.o_lk_rd_stall[1]}, {127'd0, ~i[0]});
            chk($sformatf("conf%0d_head_oe", i), {127'd0, bus.o_head_oe[1]}, {127'd0, i[0]});
            tick();
        end
        bus.i_lk_rd_vld[1] = 1'b0;
        @(negedge clk);
        chk("conf_wr_alone", {127'd0, bus.o_wb_wr_stall[1]}, 128'd0);
        tick();
        bus.i_lk_rd_vld[1] = 1'b1;
        @(negedge clk);
        chk("conf_flag_wb_wr", {127'd0, bus.o_wb_wr_stall[1]}, 128'd0);
        chk("conf_flag_wb_rd", {127'd0, bus.o_lk_rd_stall[1]}, 128'd1);
        tick();
        bus.i_wb_wr_vld[1] = 1'b0;
        @(negedge clk);
        chk("conf_rd_alone", {127'd0, bus.o_lk_rd_stall[1]}, 128'd0);
        tick();
        clr_req();

        // bank 0: tail-only write, then read back
        bus.i_wb_wr_vld[0]  = 1'b1;
        bus.i_wb_wr_sel[0]  = wr_sel_t'(3'b010);
        bus.i_wb_wr_addr[0] = 8'h05;
        bus.i_wb_wr_head[0] = 8'h77;
        bus.i_wb_wr_tail[0] = 8'h2A;
        @(negedge clk);
        chk("tw_tail_ce", {124'd0, bus.o_tail_ce}, 128'b0001);
        chk("tw_other_ce", {124'd0, bus.o_head_ce | bus.o_dat_ce}, 128'd0);
        chk("tw_tail_oe", {124'd0, bus.o_tail_oe}, 128'd0);
        chk("tw_tail_addr", {120'd0, bus.o_tail_addr[0]}, 128'h05);
        chk("tw_tail_din", {120'd0, bus.o_tail_din[0]}, 128'h2A);
        tick();
        clr_req();
        bus.i_lk_rd_vld[0]  = 1'b1;
        bus.i_lk_rd_addr[0] = 8'h05;
        tick();
        clr_req();
        @(negedge clk);
        chk("tw_dvld", {124'd0, bus.o_lk_rd_dvld}, 128'b0001);
        chk("tw_rd_tail", {120'd0, bus.o_lk_rd_tail[0]}, 128'h2A);
        chk("tw_rd_head", {120'd0, bus.o_lk_rd_head[0]}, 128'h00);

        // multi-bank arbitration table; flags entering: b0 WB, b1 LK, b2 WB, b3 WB
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int b = 0; b < BANKS_N; b++) begin
                bus.i_lk_rd_vld[b]  = vt[i].rd[b];
                bus.i_lk_rd_addr[b] = 8'hA1;
                bus.i_wb_wr_vld[b]  = vt[i].wr[b];
                bus.i_wb_wr_sel[b]  = vt[i].sel;
                bus.i_wb_wr_addr[b] = 8'hA0;
                bus.i_wb_wr_head[b] = 8'h5A;
                bus.i_wb_wr_tail[b] = 8'hA5;
                bus.i_wb_wr_dat[b]  = {4{32'hCAFE_F00D}};
            end
            @(negedge clk);
            chk($sformatf("vec%0d_rd_stall", i), {124'd0, bus.o_lk_rd_stall}, {124'd0, vt[i].rd_st});
            chk($sformatf("vec%0d_wr_stall", i), {124'd0, bus.o_wb_wr_stall}, {124'd0, vt[i].wr_st});
            chk($sformatf("vec%0d_head_ce", i),  {124'd0, bus.o_head_ce},     {124'd0, vt[i].head_ce});
            chk($sformatf("vec%0d_head_oe", i),  {124'd0, bus.o_head_oe},     {124'd0, vt[i].head_oe});
            chk($sformatf("vec%0d_dat_ce", i),   {124'd0, bus.o_dat_ce},      {124'd0, vt[i].dat_ce});
            chk($sformatf("vec%0d_dvld", i),     {124'd0, bus.o_lk_rd_dvld},  {124'd0, vt[i].dvld});
        end
        tick();
        clr_req();

        // reinit from DONE; a second pulse at sweep cycle 100 must be ignored
        bus.i_reinit = 1'b1;
        @(negedge clk);
        chk("reinit_busy_pre", {127'd0, bus.o_init_busy}, 128'd0);
        tick();
        bus.i_reinit = 1'b0;
        run_sweep("reinit", 100);

        // pending dvld dropped by async reset
        tick();
        bus.i_lk_rd_vld[3]  = 1'b1;
        bus.i_lk_rd_addr[3] = 8'h17;
        tick();
        clr_req();
        chk("pend_dvld", {124'd0, bus.o_lk_rd_dvld}, 128'b1000);
        arst_n = 1'b0;
        #1;
        chk("pend_dvld_drop", {124'd0, bus.o_lk_rd_dvld}, 128'd0);
        chk("pend_busy", {127'd0, bus.o_init_busy}, 128'd1);
        tick();
        arst_n = 1'b1;

        // async reset at sweep cycle 50 restarts the sweep from line 0
        for (int k = 0; k < 50; k++) tick();
        @(negedge clk);
        chk("mid_addr50", {120'd0, bus.o_head_addr[0]}, 128'd50);
        #1 arst_n = 1'b0;
        #1;
        chk("mid_rst_addr", {120'd0, bus.o_head_addr[0]}, 128'd0);
        chk("mid_rst_busy", {127'd0, bus.o_init_busy}, 128'd1);
        chk("mid_rst_stall", {124'd0, bus.o_wb_wr_stall}, 128'hF);
        tick();
        arst_n = 1'b1;
        run_sweep("restart", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stk_pipe_mem_ctrl.md
Name: stk_pipe_mem_ctrl

Overview:
Sequencer/arbiter in front of the banked head, tail and data SRAMs of the stk pipeline.
- After reset (or on request), sweeps every line of every bank, writing the initial value.
- Then shares each bank's single SRAM port between the lookup (LK) read requester and the writeback (WB) write requester.
- Drives the SRAM ce/oe/addr/din buses directly. Returns read data with a valid strobe.

Parameters:
BANKS_N, 4, number of SRAM banks (mirrors stk_pkg::BANKS_N)
LINES_N, 256, lines per bank; power of two, >= 2
DATA_W, 128, data SRAM word width

Ports:
clk  in  1  clock
arst_n  in  1  reset; asynchronous, active-low
i_reinit  in  1  pulse: restart the init sweep (accepted only in DONE)
o_init_busy  out  1  high while the sweep is in progress
i_lk_rd_vld  in  BANKS_N  per-bank read request (head+tail+data at one address)
i_lk_rd_addr  in  BANKS_N*LINE_W  per-bank read address; LINE_W=$clog2(LINES_N)
o_lk_rd_stall  out  BANKS_N  read not accepted this cycle; requester holds request
o_lk_rd_dvld  out  BANKS_N  read data valid (one cycle after acceptance)
o_lk_rd_head  out  BANKS_N*LINE_W  head SRAM dout pass-through
o_lk_rd_tail  out  BANKS_N*LINE_W  tail SRAM dout pass-through
o_lk_rd_dat  out  BANKS_N*DATA_W  data SRAM dout pass-through
i_wb_wr_vld  in  BANKS_N  per-bank write request
i_wb_wr_sel  in  BANKS_N*3  per-bank select {dat,tail,head}
i_wb_wr_addr  in  BANKS_N*LINE_W  write address
i_wb_wr_head, i_wb_wr_tail  in  BANKS_N*LINE_W  write data
i_wb_wr_dat  in  BANKS_N*DATA_W  write data
o_wb_wr_stall  out  BANKS_N  write not accepted this cycle
o_{head,tail,dat}_ce, o_{head,tail,dat}_oe  out  BANKS_N each  SRAM controls (ce=1,oe=1 read; ce=1,oe=0 write)
o_{head,tail,dat}_addr  out  BANKS_N*LINE_W each  SRAM address
o_{head,tail,dat}_din  out  per-SRAM width  SRAM write data
i_{head,tail,dat}_dout  in  per-SRAM width  SRAM read data (valid one cycle after a read ce)

Behaviour:
- One clock (clk); reset arst_n asynchronous, active-low.
- Reset values:
  - FSM=INIT, counter=0, o_init_busy=1.
  - o_lk_rd_dvld=0; per-bank priority flag=WB.
  - All SRAM ce=0 except as driven by INIT.
- FSM states: INIT, DONE.
- INIT:
  - Each cycle, every bank writes its head and tail SRAMs at addr=counter with din=0 (ce=1, oe=0).
  - Counter increments each cycle; at LINES_N-1 go to DONE the next cycle. Sweep length is exactly LINES_N cycles.
  - All o_lk_rd_stall=1 and o_wb_wr_stall=1; o_init_busy=1.
- DONE:
  - o_init_busy=0.
  - i_reinit=1 -> INIT with counter=0 next cycle. i_reinit during INIT is ignored; the sweep is not restarted.
- Arbitration, per bank, independent, DONE only:
  - Only one of read or write is issued per bank per cycle.
  - Single requester: it is granted and its stall=0.
  - Both requesting: grant the side named by the priority flag. The other side stalls (combinational, same cycle). The flag then toggles to the loser.
  - Flag is unchanged when there is no conflict. Consecutive conflicts therefore alternate WB, LK, WB... Neither side starves.
- Write grant:
  - ce=1, oe=0 on each SRAM whose sel bit is set; ce=0 on the others.
  - sel=0 with vld=1 is accepted as a no-op.
- Read grant:
  - ce=1, oe=1 on all three SRAMs at i_lk_rd_addr.
  - o_lk_rd_dvld[b]=1 on the next cycle; dout passes through combinationally.
- Same address, same cycle: write wins or read wins per the flag. No forwarding; a read issued after a write sees the new value.
- Reset mid-sweep or mid-transaction: immediate return to the reset state. A pending dvld is dropped.
- Requester contract: vld/addr/data stay stable while stall=1. Violations are flagged by the assertion.

Optional Feature:
STK_MEM_CTRL_INIT_DAT_EN
- Defined: INIT also writes data SRAMs (din=0) in the same cycles.
- Undefined: data SRAM ce=0 throughout INIT; data contents are undefined after reset.

Decomposition:
- stk_pkg holds BANKS_N, LINES_N, line_id_t, bank_id_t, ctrl_state_t (INIT/DONE), wr_sel_t (3-bit {dat,tail,head}).
- Natural sub-module: stk_pipe_mem_ctrl_bank_arb. Per-bank grant logic and priority flag; generated BANKS_N times.
- Top level keeps the FSM, sweep counter and output muxing.

Test Plan:
- Reset release, LINES_N=256 -> o_init_busy high for exactly 256 cycles; head/tail ce=1, oe=0, addr 0..255, din=0 on all banks; then stall=0.
- DONE, bank 2 read addr 0x17 only -> head/tail/dat ce=1, oe=1, addr 0x17; o_lk_rd_dvld[2]=1 next cycle with dout passed through.
- Bank 1 read+write held 4 cycles -> grants WB, LK, WB, LK; stalls mirror the grants; flag ends at WB.
- Write sel=3'b010 addr 0x05 din 0x2A -> only tail ce=1, oe=0; a following read of 0x05 returns tail=0x2A.
- i_reinit in DONE -> busy high for 256 cycles; a second i_reinit at sweep cycle 100 is ignored (busy still falls at cycle 256).
- arst_n low at sweep cycle 50 -> outputs return to reset values; the sweep restarts at 0 after release.
